// File: rtl/voice_mixer_pkg.sv
// rtl/voice_mixer_pkg.sv - shared constants and state type for the voice mixer
package voice_mixer_pkg;

    localparam int N_OSCILLATORS    = 4;
    localparam int SAMPLE_WIDTH     = 16;
    localparam int FIXED_POINT      = 0;
    localparam int MIXER_GAIN_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } mixer_state_t;

endpackage

// File: rtl/voice_mixer_if.sv
// rtl/voice_mixer_if.sv - voice sample/gain inputs and mixed sample outputs
interface voice_mixer_if #(
    parameter int N_VOICES   = voice_mixer_pkg::N_OSCILLATORS,
    parameter int DATA_WIDTH = voice_mixer_pkg::SAMPLE_WIDTH + voice_mixer_pkg::FIXED_POINT,
    parameter int GAIN_WIDTH = voice_mixer_pkg::MIXER_GAIN_WIDTH,
    parameter int OUT_WIDTH  = voice_mixer_pkg::SAMPLE_WIDTH
);
    logic                         sample_tick;
    logic signed [DATA_WIDTH-1:0] samples [N_VOICES];
    logic        [GAIN_WIDTH-1:0] gains   [N_VOICES];
    logic        [N_VOICES-1:0]   enables;
    logic signed [OUT_WIDTH-1:0]  out_sample;
    logic                         out_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output sample_tick, samples, gains, enables,
        input  out_sample, out_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, samples, gains, enables,
        output out_sample, out_valid, busy, overrun
    );

endinterface

// File: rtl/saturating_shifter.sv
// rtl/saturating_shifter.sv - arithmetic right shift followed by signed clamp
module saturating_shifter #(
    parameter int IN_WIDTH  = 27,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8
) (
    input  logic signed [IN_WIDTH-1:0]  in_value,
    output logic signed [OUT_WIDTH-1:0] out_value
);
    localparam logic signed [IN_WIDTH-1:0] MAX_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MIN_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH-1:0] shifted;

    // Floor-shift, then clamp into the representable output range
    always_comb begin
        shifted = in_value >>> SHIFT;
        if (shifted > MAX_V) begin
            out_value = MAX_V[OUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            out_value = MIN_V[OUT_WIDTH-1:0];
        end else begin
            out_value = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - time-multiplexed weighted voice mixer with one shared multiplier
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int N_VOICES   = N_OSCILLATORS,
    parameter int DATA_WIDTH = SAMPLE_WIDTH + FIXED_POINT,
    parameter int GAIN_WIDTH = MIXER_GAIN_WIDTH,
    parameter int OUT_WIDTH  = SAMPLE_WIDTH,
    parameter int OUT_SHIFT  = GAIN_WIDTH
) (
    input  logic          sys_clk,
    input  logic          rst,
    voice_mixer_if.slave  bus
);
    localparam int IW = $clog2(N_VOICES);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int AW = PW + $clog2(N_VOICES);

    mixer_state_t state, next_state;

    logic [IW-1:0]         idx;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc;
    logic signed [PW-1:0]  sample_ext;
    logic signed [PW-1:0]  gain_ext;
    logic signed [PW-1:0]  mult;
    logic signed [OUT_WIDTH-1:0] sat_value;
    logic                  last_voice;
    logic                  do_start, do_accum, do_drain, do_emit;

    assign last_voice = (idx == IW'(N_VOICES - 1));

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: walk every voice once, one extra add, then emit
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.sample_tick) next_state = ACCUM;
            ACCUM:   if (last_voice) next_state = DRAIN;
            DRAIN:   next_state = OUTPUT;
            OUTPUT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state datapath controls and busy flag
    always_comb begin
        do_start = (state == IDLE) && bus.sample_tick;
        do_accum = (state == ACCUM);
        do_drain = (state == DRAIN);
        do_emit  = (state == OUTPUT);
        bus.busy = (state != IDLE);
    end

    // Single shared multiplier on the currently issued voice; inputs are read live
    always_comb begin
        sample_ext = PW'(bus.samples[idx]);
        gain_ext   = PW'({1'b0, bus.gains[idx]});
        mult       = bus.enables[idx] ? (sample_ext * gain_ext) : '0;
    end

    saturating_shifter #(
        .IN_WIDTH  (AW),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (OUT_SHIFT)
    ) u_sat (
        .in_value  (acc),
        .out_value (sat_value)
    );

    // Index, product pipeline register, accumulator, output and sticky overrun
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            prod           <= '0;
            acc            <= '0;
            bus.out_sample <= '0;
            bus.out_valid  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.out_valid <= do_emit;
            if (bus.sample_tick && (state != IDLE)) begin
                bus.overrun <= 1'b1;
            end
            if (do_start) begin
                idx  <= '0;
                prod <= '0;
                acc  <= '0;
            end
            if (do_accum) begin
                prod <= mult;
                acc  <= acc + AW'(prod);
                idx  <= idx + 1'b1;
            end
            if (do_drain) begin
                acc <= acc + AW'(prod);
            end
            if (do_emit) begin
                bus.out_sample <= sat_value;
            end
        end
    end

endmodule
